ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_pkg.sv | 35 +++
 rtl/ifetch_decode.sv | 14 +
 rtl/ifetch_unit.sv | 106 ++++++++++
 tb/tb_ifetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Opcode set, FSM state encoding and the default reset PC.
package ifetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  // Logical immediates are zero-extended, everything else sign-extended.
  function automatic logic sign_ext(input logic [5:0] op);
    logic s;
    s = 1'b1;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: s = 1'b0;
      default: s = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ifetch_decode.sv
// Immediate field and extender select derived from the fetched word.
// Purely combinational.
module ifetch_decode
  import ifetch_pkg::*;
(
  input  logic [31:0] instr,
  output logic [15:0] imm16,
  output logic        ext_sel
);

  assign imm16   = instr[15:0];
  assign ext_sel = sign_ext(instr[31:26]);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch FSM: request, register, hold for decode, redirect.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirects.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [15:0] if_imm16,
  output logic        if_ext_sel,
  output logic        if_fault
);

  state_t      state;
  logic [29:0] pc_w;
  if_id_t      id_q;
  logic        misal;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q;
  assign misal    = br_target[1:0] != 2'b00;
  assign if_fault = fault_q;
`else
  logic unused_tgt;
  assign unused_tgt = ^br_target[1:0];
  assign misal      = 1'b0;
  assign if_fault   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc_w     <= RESET_PC[31:2];
      id_q     <= '0;
      if_valid <= 1'b0;
      imem_req <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else if (state != FAULT && br_taken) begin
      if_valid <= 1'b0;
      if (misal) begin
        state    <= FAULT;
        imem_req <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        fault_q  <= 1'b1;
`endif
      end else begin
        state    <= FETCH;
        pc_w     <= br_target[31:2];
        imem_req <= 1'b1;
      end
    end else begin
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            id_q.instr <= imem_rdata;
            id_q.pc    <= {pc_w, 2'b00};
            pc_w       <= pc_w + 30'd1;
            if_valid   <= 1'b1;
            imem_req   <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (id_ready) begin
            if_valid <= 1'b0;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        FAULT: begin
          if_valid <= 1'b0;
          imem_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_addr = {pc_w, 2'b00};
  assign if_instr  = id_q.instr;
  assign if_pc     = id_q.pc;

  ifetch_decode u_dec (
    .instr   (id_q.instr),
    .imm16   (if_imm16),
    .ext_sel (if_ext_sel)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed vector bench for ifetch_unit, plus a second instance
// built with RESET_PC at the top of the address space.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, id_ready, br_taken;
  logic [31:0] imem_addr, imem_rdata, br_target;
  logic        if_valid, if_ext_sel, if_fault;
  logic [31:0] if_instr, if_pc;
  logic [15:0] if_imm16;

  logic        req2, valid2, ext2, fault2;
  logic [31:0] addr2, instr2, pc2;
  logic [15:0] imm2;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .br_taken(br_taken),
    .br_target(br_target), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc),
    .if_imm16(if_imm16), .if_ext_sel(if_ext_sel),
    .if_fault(if_fault)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .br_taken(br_taken),
    .br_target(br_target), .if_valid(valid2),
    .if_instr(instr2), .if_pc(pc2),
    .if_imm16(imm2), .if_ext_sel(ext2),
    .if_fault(fault2)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ext;
    logic [15:0] imm;
    logic        fault;
  } vec_t;

  localparam int NV = 18;
  vec_t tv[NV];

  function automatic vec_t mk(
    input logic a, input logic [31:0] d, input logic r,
    input logic b, input logic [31:0] t,
    input logic q, input logic [31:0] ad, input logic v,
    input logic [31:0] in, input logic [31:0] p,
    input logic e, input logic [15:0] im, input logic f
  );
    vec_t x;
    x.ack = a; x.rdata = d; x.rdy = r; x.br = b; x.tgt = t;
    x.req = q; x.addr = ad; x.valid = v; x.instr = in;
    x.pc = p; x.ext = e; x.imm = im; x.fault = f;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " req"}, 32'(imem_req), 32'(v.req));
    chk({tag, " addr"}, imem_addr, v.addr);
    chk({tag, " valid"}, 32'(if_valid), 32'(v.valid));
    chk({tag, " instr"}, if_instr, v.instr);
    chk({tag, " pc"}, if_pc, v.pc);
    chk({tag, " ext"}, 32'(if_ext_sel), 32'(v.ext));
    chk({tag, " imm"}, 32'(if_imm16), 32'(v.imm));
    chk({tag, " fault"}, 32'(if_fault), 32'(v.fault));
  endtask

  task automatic drive(input logic a, input logic [31:0] d,
                       input logic r, input logic b,
                       input logic [31:0] t);
    imem_ack = a; imem_rdata = d; id_ready = r;
    br_taken = b; br_target = t;
  endtask

  initial begin
    vec_t z;
    tv[0]  = mk(1, 32'h3401_FFFF, 0, 0, 0,
                0, 32'h4, 1, 32'h3401_FFFF, 32'h0, 0, 16'hFFFF, 0);
    tv[1]  = mk(0, 0, 1, 0, 0,
                1, 32'h4, 0, 32'h3401_FFFF, 32'h0, 0, 16'hFFFF, 0);
    tv[2]  = mk(1, 32'h2001_FFFF, 1, 0, 0,
                0, 32'h8, 1, 32'h2001_FFFF, 32'h4, 1, 16'hFFFF, 0);
    tv[3]  = mk(0, 0, 1, 0, 0,
                1, 32'h8, 0, 32'h2001_FFFF, 32'h4, 1, 16'hFFFF, 0);
    tv[4]  = mk(0, 0, 0, 0, 0,
                1, 32'h8, 0, 32'h2001_FFFF, 32'h4, 1, 16'hFFFF, 0);
    tv[5]  = mk(1, 32'h3C01_1234, 0, 0, 0,
                0, 32'hC, 1, 32'h3C01_1234, 32'h8, 0, 16'h1234, 0);
    tv[6]  = mk(0, 0, 0, 0, 0,
                0, 32'hC, 1, 32'h3C01_1234, 32'h8, 0, 16'h1234, 0);
    tv[7]  = mk(1, 32'hDEAD_BEEF, 0, 0, 0,
                0, 32'hC, 1, 32'h3C01_1234, 32'h8, 0, 16'h1234, 0);
    tv[8]  = tv[6];
    tv[9]  = tv[6];
    tv[10] = tv[6];
    tv[11] = mk(0, 0, 1, 0, 0,
                1, 32'hC, 0, 32'h3C01_1234, 32'h8, 0, 16'h1234, 0);
    tv[12] = mk(1, 32'hAAAA_AAAA, 0, 1, 32'h100,
                1, 32'h100, 0, 32'h3C01_1234, 32'h8, 0, 16'h1234, 0);
    tv[13] = mk(1, 32'h8C22_0004, 0, 0, 0,
                0, 32'h104, 1, 32'h8C22_0004, 32'h100, 1, 16'h0004, 0);
    tv[14] = mk(0, 0, 1, 1, 32'h200,
                1, 32'h200, 0, 32'h8C22_0004, 32'h100, 1, 16'h0004, 0);
`ifdef IFETCH_ALIGN_CHECK_EN
    tv[15] = mk(0, 0, 0, 1, 32'h102,
                0, 32'h200, 0, 32'h8C22_0004, 32'h100, 1, 16'h0004, 1);
    tv[16] = mk(1, 32'h1111_1111, 1, 0, 0,
                0, 32'h200, 0, 32'h8C22_0004, 32'h100, 1, 16'h0004, 1);
    tv[17] = mk(0, 0, 0, 1, 32'h300,
                0, 32'h200, 0, 32'h8C22_0004, 32'h100, 1, 16'h0004, 1);
`else
    tv[15] = mk(0, 0, 0, 1, 32'h102,
                1, 32'h100, 0, 32'h8C22_0004, 32'h100, 1, 16'h0004, 0);
    tv[16] = mk(1, 32'h1111_1111, 1, 0, 0,
                0, 32'h104, 1, 32'h1111_1111, 32'h100, 1, 16'h1111, 0);
    tv[17] = mk(0, 0, 0, 1, 32'h300,
                1, 32'h300, 0, 32'h1111_1111, 32'h100, 1, 16'h1111, 0);
`endif

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    z = mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1, 16'h0, 0);
    chk_all("reset", z);
    chk("reset addr2", addr2, 32'hFFFF_FFFC);

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    z.req = 1'b1;
    chk_all("idle2fetch", z);
    chk("fetch addr2", addr2, 32'hFFFF_FFFC);
    chk("fetch req2", 32'(req2), 32'h1);

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].ack, tv[i].rdata, tv[i].rdy, tv[i].br, tv[i].tgt);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tv[i]);
      if (i == 0) begin
        chk("wrap addr2", addr2, 32'h0000_0000);
        chk("wrap pc2", pc2, 32'hFFFF_FFFC);
      end
    end

    // asynchronous reset in mid-cycle with an ack pending
    drive(1, 32'h5555_5555, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    z = mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1, 16'h0, 0);
    chk_all("async_rst", z);
    @(posedge clk);
    #1;
    chk_all("rst_hold", z);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    z.req = 1'b1;
    chk_all("rst_release", z);
    @(posedge clk);
    #1;
    z = mk(0, 0, 0, 0, 0, 0, 32'h4, 1, 32'h5555_5555, 32'h0, 1,
           16'h5555, 0);
    chk_all("post_rst_ack", z);
    drive(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
